seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=4, power of two).
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports: A, B  input  WIDTH  operands.
REQ-007 SHALL have port: ALUop  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: ALUout  output  WIDTH  registered result.
REQ-011 SHALL have ports: Z, N, C, V  output  1 each  zero, negative, carry, signed overflow flags.

Function
REQ-012 SHALL capture A, B and ALUop on acceptance (in_valid && in_ready at a rising edge); later input changes SHALL be ignored.
REQ-013 SHALL implement FSM IDLE -> EXEC (MUL only) -> DONE -> IDLE.
REQ-014 SHALL assert in_ready in IDLE, and in DONE when out_ready is high (back-to-back acceptance in the same cycle as result handoff); otherwise low.
REQ-015 SHALL, for ADD/SUB/AND/OR/XOR/SLL/SRL, go IDLE->DONE so out_valid rises on the first edge after acceptance.
REQ-016 SHALL, for MUL, iterate shift-add over WIDTH EXEC edges; out_valid rises on edge WIDTH after acceptance.
REQ-017 SHALL use shift amount B[log2(WIDTH)-1:0]; SLL/SRL are logical, zero-fill.
REQ-018 SHALL keep ALUout as the low WIDTH bits of the result; MUL is unsigned.
REQ-019 SHALL set Z = (ALUout == 0), N = ALUout[WIDTH-1] for every op.
REQ-020 SHALL set C = carry out for ADD; carry out of A + ~B + 1 for SUB (1 = no borrow); 1 when upper product half is nonzero for MUL; 0 otherwise.
REQ-021 SHALL set V = two's-complement overflow for ADD/SUB; 0 otherwise.
REQ-022 SHALL hold ALUout and flags stable while out_valid && !out_ready.
REQ-023 SHALL deassert out_valid on handoff unless a new single-cycle op was accepted in the same cycle, in which case out_valid remains high with the new result.

Reset
REQ-024 SHALL, while rst is high, force state IDLE, in_ready=0, out_valid=0, ALUout=0, Z=N=C=V=0, MUL counter=0.
REQ-025 SHALL, on rst mid-EXEC, abandon the operation; no result is emitted after release.
REQ-026 SHALL raise in_ready on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL compile MUL (EXEC state, iteration counter, multiplier) only when ALU_MUL_EN is defined.
REQ-028 SHALL, without ALU_MUL_EN, treat ALUop 111 as single-cycle with ALUout=0, Z=1, N=C=V=0, and never enter EXEC.

Structure
REQ-029 SHALL place ALUop encodings and FSM state type in shared package alu_pkg.
REQ-030 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, done, WIDTH parameter), instantiated only under ALU_MUL_EN.

Verification
REQ-031 SHALL cover: WIDTH=8, ADD 8'h7F+8'h01 -> one cycle later ALUout=8'h80, N=1, V=1, C=0, Z=0.
REQ-032 SHALL cover: SUB 8'd5-8'd5 -> ALUout=0, Z=1, C=1, V=0; SUB 8'd3-8'd5 -> 8'hFE, C=0, N=1.
REQ-033 SHALL cover: MUL 8'd15*8'd17 -> ALUout=8'hFF, C=0, out_valid exactly 8 cycles after acceptance, in_ready low throughout; MUL 8'd16*8'd16 -> ALUout=0, Z=1, C=1.
REQ-034 SHALL cover: out_ready low 3 cycles after XOR result -> outputs stable, in_ready low; then out_ready=1 with in_valid=1 (OR) -> accepted same cycle, out_valid stays high, new result next edge.
REQ-035 SHALL cover: rst pulsed on 4th EXEC cycle of MUL -> all outputs 0 immediately, no out_valid after release, in_ready=1 one edge later.
REQ-036 SHALL cover: build without ALU_MUL_EN, ALUop 111 with A=B=8'h0F -> one cycle later ALUout=0, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU opcode encodings and control FSM state type for
//            seq_alu. EXEC exists only when ALU_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
        ST_EXEC = 2'd1,
`endif
        ST_DONE = 2'd2
    } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Purpose  : Unsigned shift-add multiplier. A start pulse loads the operands;
//            one partial product is accumulated per clock for WIDTH clocks.
//            done pulses (combinationally) during the final iteration, with
//            product showing the completed 2*WIDTH-bit result in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               busy_q,  busy_d;
    logic [2*WIDTH-1:0] addend;

    // Iteration step: add the shifted multiplicand when the current
    // multiplier bit is set, then advance both shifters and the counter.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;
        addend   = mplier_q[0] ? mcand_q : '0;
        product  = acc_q + addend;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Multiplier datapath registers; reset abandons any iteration in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Sequential ALU with valid/ready handshakes on both sides.
//            Single-cycle ops present their result right after the accepting
//            edge; MUL (only when ALU_MUL_EN is defined) runs WIDTH iterations
//            in EXEC first. Without ALU_MUL_EN, opcode 111 yields zero.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             init_q,  init_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             accept;

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_iter #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle datapath evaluated straight from the inputs; its result is
    // only registered on the accepting edge, which is the operand capture.
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        shamt   = B[SH_W-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_MUL:  alu_res = '0;
        endcase
    end

    // Handshake and next-state logic: DONE hands off and may accept a new op
    // in the same cycle; MUL detours through EXEC until the multiplier ends.
    always_comb begin
        state_d   = state_q;
        init_d    = 1'b1;
        res_d     = res_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
`ifdef ALU_MUL_EN
        mul_start = 1'b0;
`endif
        in_ready  = init_q && ((state_q == ST_IDLE) ||
                               ((state_q == ST_DONE) && out_ready));
        accept    = in_valid && in_ready;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (ALUop == OP_MUL) begin
                        state_d   = ST_EXEC;
                        mul_start = 1'b1;
                    end else
`endif
                    begin
                        state_d = ST_DONE;
                        res_d   = alu_res;
                        z_d     = (alu_res == '0);
                        n_d     = alu_res[WIDTH-1];
                        c_d     = alu_c;
                        v_d     = alu_v;
                    end
                end
            end
`ifdef ALU_MUL_EN
            ST_EXEC: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                    res_d   = mul_product[WIDTH-1:0];
                    z_d     = (mul_product[WIDTH-1:0] == '0);
                    n_d     = mul_product[WIDTH-1];
                    c_d     = |mul_product[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers; init_q keeps in_ready low until the
    // first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign ALUout    = res_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Scoreboard bench for seq_alu (WIDTH=8). Follows ALU_MUL_EN the
//            same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_alu;

    localparam int W    = 8;
    localparam int MOD  = 1 << W;
    localparam int MAXS = MOD/2 - 1;
    localparam int MINS = -(MOD/2);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid;
    logic [W-1:0] A = '0, B = '0, aluout;
    logic [2:0]   ALUop = '0;
    logic         z, n, c, v;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
        .ALUout(aluout), .Z(z), .N(n), .C(c), .V(v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic z, n, c, v;
        int   acc;
        int   due;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         or_mode = 1'b0, or_force = 1'b0;
    bit         rdy_chk = 1'b0, front_seen = 1'b0, hold_prev = 1'b0;
    logic [W+3:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   r;
        longint ua = a, ub = b, full = 0, s = 0;
        int     sa = $signed(a), sb = $signed(b);
        r.c = 1'b0; r.v = 1'b0;
        case (op)
            3'd0: begin full = ua + ub; r.c = (full >= MOD); s = sa + sb; r.v = (s > MAXS) || (s < MINS); end
            3'd1: begin full = ua - ub; if (full < 0) full += MOD; r.c = (ua >= ub);
                        s = sa - sb; r.v = (s > MAXS) || (s < MINS); end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: full = ua << (ub % W);
            3'd6: full = ua >> (ub % W);
            default: begin
                if (MUL_EN) begin full = ua * ub; r.c = (full >= MOD); end
                else full = 0;
            end
        endcase
        r.res = W'(full % MOD);
        r.z   = (r.res == 0);
        r.n   = (r.res >= MOD/2);
        r.acc = 0; r.due = 0;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] corners [5] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h01};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    // Consumer: random back-pressure unless a directed test forces it.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = or_mode ? or_force : ($urandom_range(0, 9) < 7);
        end
    end

    task automatic set_or(input bit val);
        or_mode = 1'b1; or_force = val; out_ready = val;
    endtask

    // Monitor: pops and compares on every result handoff.
    initial begin
        bit pend;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                hold_prev = 1'b0; front_seen = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", {aluout, z, n, c, v}, held);
                end
                hold_prev = out_valid && !out_ready;
                held = {aluout, z, n, c, v};
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", out_valid, 0);
                    end else begin
                        if (!front_seen) begin
                            chk("latency", cyc, q[0].due);
                            front_seen = 1'b1;
                        end
                        chk("result", {aluout, z, n, c, v},
                            {q[0].res, q[0].z, q[0].n, q[0].c, q[0].v});
                        if (out_ready) begin
                            void'(q.pop_front());
                            front_seen = 1'b0;
                        end
                    end
                    if (rdy_chk) chk("in_ready_done", in_ready, out_ready);
                end else if (rdy_chk) begin
                    pend = (q.size() > 0) && (q[0].acc <= cyc);
                    chk("in_ready_idle_exec", in_ready, !pend);
                end
            end
        end
    end

    // Starts and ends at a negedge; scrambles the inputs after acceptance.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        exp_t e;
        waited = 0;
        in_valid = 1'b1; ALUop = op; A = a; B = b;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk); #1; waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
        end else begin
            e = model(op, a, b);
            e.acc = cyc + 1;
            e.due = e.acc + ((op == 3'b111 && MUL_EN) ? W : 0);
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0; A = W'($urandom); B = W'($urandom); ALUop = 3'($urandom);
    endtask

    task automatic expect_first(input string name, input logic [W-1:0] res, input logic [3:0] f);
        int k = 0;
        #3;
        while (!out_valid && k < 40) begin @(negedge clk); #3; k++; end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_res"}, aluout, res);
        chk({name, "_zncv"}, {z, n, c, v}, f);
        @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        or_mode = 1'b0;
        while ((q.size() != 0 || out_valid) && k < 300) begin @(negedge clk); k++; end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [W-1:0] ra, rb, xs;
        logic [3:0]   xf;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_aluout", aluout, 0);
        chk("rst_flags", {z, n, c, v}, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk); #1 chk("in_ready_after_edge", in_ready, 1);
        @(negedge clk); rdy_chk = 1'b1;

        issue(3'd0, 8'h7F, 8'h01, w); expect_first("add_ovf", 8'h80, 4'b0101);
        drain();
        issue(3'd1, 8'd5, 8'd5, w);   expect_first("sub_eq", 8'h00, 4'b1010);
        drain();
        issue(3'd1, 8'd3, 8'd5, w);   expect_first("sub_borrow", 8'hFE, 4'b0100);
        drain();
`ifdef ALU_MUL_EN
        issue(3'd7, 8'd15, 8'd17, w); expect_first("mul_255", 8'hFF, 4'b0100);
        drain();
        issue(3'd7, 8'd16, 8'd16, w); expect_first("mul_256", 8'h00, 4'b1010);
        drain();
`else
        issue(3'd7, 8'h0F, 8'h0F, w); expect_first("mul_off", 8'h00, 4'b1000);
        drain();
`endif

        // Stall the consumer on an XOR result, then hand off while accepting OR.
        set_or(1'b0);
        ra = 8'hA5; rb = 8'h3C;
        issue(3'd4, ra, rb, w);
        #3;
        chk("stall_valid", out_valid, 1);
        xs = aluout; xf = {z, n, c, v};
        chk("stall_xor", xs, ra ^ rb);
        repeat (3) begin
            @(negedge clk); #3;
            chk("stall_stable_res", aluout, xs);
            chk("stall_stable_flags", {z, n, c, v}, xf);
            chk("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        set_or(1'b1);
        issue(3'd3, 8'h50, 8'h0A, w);
        chk("b2b_accept_wait", w, 0);
        #3;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_or", aluout, 8'h5A);
        @(negedge clk);
        drain();

`ifdef ALU_MUL_EN
        // Reset in the 4th EXEC cycle of a multiply.
        issue(3'd7, 8'hD3, 8'h9B, w);
        repeat (3) @(negedge clk);
        rst = 1'b1; rdy_chk = 1'b0; q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_aluout", aluout, 0);
        chk("midrst_flags", {z, n, c, v}, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("midrst_ready_low", in_ready, 0);
        @(posedge clk); #1 chk("midrst_ready_high", in_ready, 1);
        @(negedge clk); rdy_chk = 1'b1;
        repeat (12) @(negedge clk);
`endif

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), w);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_alu
`default_nettype wire
